// File: rtl/pipeline_stall_ctrl.sv
// Decode-stage stall/flush controller: turns data/control hazards into pipeline
// stall, flush and bubble controls and returns one clear pulse per issued call/ret/branch.
module pipeline_stall_ctrl #(
    parameter int BR_LAT = 1,
    parameter int CR_LAT = 2,
    parameter int CNT_W  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic data_hazard,
    input  logic control_hazard,
    input  logic id_valid,
    input  logic id_call,
    input  logic id_ret,
    input  logic id_branch,
    input  logic br_taken,
    output logic pc_stall,
    output logic ifid_stall,
    output logic ifid_flush,
    output logic idex_bubble,
    output logic redirect,
    output logic clr_call_haz,
    output logic clr_ret_haz,
    output logic clr_branch_haz,
    output logic ctrl_err,
    output logic busy
);

    typedef enum logic {
        RUN       = 1'b0,
        CTRL_WAIT = 1'b1
    } state_t;

    localparam int T_CALL = 0;
    localparam int T_RET  = 1;
    localparam int T_BR   = 2;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       type_reg, type_next;
    logic             ctrl_err_reg, ctrl_err_next;

    logic             issue;
    logic             resolve;
    logic             first_wait;
    logic [2:0]       issue_type;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] type_lat;
    logic [2:0]       clr_vec;

    // Priority decode: call > ret > branch
    always_comb begin
        issue_type = 3'b000;
        if (id_call)
            issue_type = 3'b001;
        else if (id_ret)
            issue_type = 3'b010;
        else if (id_branch)
            issue_type = 3'b100;
    end

    assign issue_cnt  = (id_call || id_ret) ? CNT_W'(CR_LAT) : CNT_W'(BR_LAT);
    assign issue      = (state_reg == RUN) && !data_hazard && id_valid && (issue_type != 3'b000);
    assign resolve    = (state_reg == CTRL_WAIT) && (cnt_reg == CNT_W'(1));
    assign type_lat   = type_reg[T_BR] ? CNT_W'(BR_LAT) : CNT_W'(CR_LAT);
    // The detector raises its sticky flag one edge after issue, so the first wait cycle may still see it low
    assign first_wait = (state_reg == CTRL_WAIT) && (cnt_reg == type_lat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            cnt_reg      <= '0;
            type_reg     <= 3'b000;
            ctrl_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            type_reg     <= type_next;
            ctrl_err_reg <= ctrl_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        type_next     = type_reg;
        ctrl_err_next = ctrl_err_reg;
        case (state_reg)
            RUN: begin
                if (control_hazard)
                    ctrl_err_next = 1'b1;
                if (issue) begin
                    state_next = CTRL_WAIT;
                    type_next  = issue_type;
                    cnt_next   = issue_cnt;
                end
            end
            CTRL_WAIT: begin
                if (!control_hazard && !first_wait)
                    ctrl_err_next = 1'b1;
                cnt_next = cnt_reg - CNT_W'(1);
                if (resolve) begin
                    state_next = RUN;
                    type_next  = 3'b000;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
                type_next  = 3'b000;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_clr
            assign clr_vec[gi] = resolve & type_reg[gi];
        end
    endgenerate

    assign busy           = (state_reg == CTRL_WAIT);
    assign pc_stall       = busy | data_hazard;
    assign ifid_stall     = !busy & data_hazard;
    assign ifid_flush     = busy;
    assign idex_bubble    = data_hazard;
    assign redirect       = resolve & (type_reg[T_CALL] | type_reg[T_RET] | (type_reg[T_BR] & br_taken));
    assign clr_call_haz   = clr_vec[T_CALL];
    assign clr_ret_haz    = clr_vec[T_RET];
    assign clr_branch_haz = clr_vec[T_BR];
    assign ctrl_err       = ctrl_err_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table, hand-written reset/error
// sequences, and a randomized run against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam int BR_LAT = 1;
    localparam int CR_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data_hazard = 1'b0, control_hazard = 1'b0, id_valid = 1'b0;
    logic id_call = 1'b0, id_ret = 1'b0, id_branch = 1'b0, br_taken = 1'b0;
    logic pc_stall, ifid_stall, ifid_flush, idex_bubble, redirect;
    logic clr_call_haz, clr_ret_haz, clr_branch_haz, ctrl_err, busy;

    int checks = 0;
    int errors = 0;

    pipeline_stall_ctrl #(.BR_LAT(BR_LAT), .CR_LAT(CR_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .data_hazard(data_hazard), .control_hazard(control_hazard),
        .id_valid(id_valid), .id_call(id_call), .id_ret(id_ret),
        .id_branch(id_branch), .br_taken(br_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .redirect(redirect),
        .clr_call_haz(clr_call_haz), .clr_ret_haz(clr_ret_haz),
        .clr_branch_haz(clr_branch_haz), .ctrl_err(ctrl_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // stim = {dh, valid, call, ret, branch, taken, ch}
    // exp  = {pc_stall, ifid_stall, ifid_flush, idex_bubble, redirect, clr_call, clr_ret, clr_br, ctrl_err, busy}
    typedef struct packed {
        logic [6:0] stim;
        logic [9:0] exp;
    } vec_t;

    vec_t tbl [17];

    // Behavioural model: an outstanding control instruction with cycles remaining
    bit m_wait, m_first, m_err;
    int m_rem, m_kind;   // kind: 0 call, 1 ret, 2 branch

    task automatic model_reset();
        m_wait = 0; m_first = 0; m_err = 0; m_rem = 0; m_kind = 0;
    endtask

    function automatic logic [9:0] model_expect(input logic [6:0] s);
        logic dh, t;
        logic [9:0] e;
        dh = s[6]; t = s[1];
        e = '0;
        if (!m_wait) begin
            e[9] = dh; e[8] = dh; e[6] = dh;
        end else begin
            e[9] = 1; e[7] = 1; e[6] = dh; e[0] = 1;
            if (m_rem == 1) begin
                e[4 - m_kind] = 1;
                e[5] = (m_kind != 2) || t;
            end
        end
        e[1] = m_err;
        return e;
    endfunction

    task automatic model_step(input logic [6:0] s);
        logic dh, v, c, r, b, ch;
        {dh, v, c, r, b} = s[6:2];
        ch = s[0];
        if (!m_wait) begin
            if (ch) m_err = 1;
            if (!dh && v && (c || r || b)) begin
                m_wait = 1; m_first = 1;
                m_kind = c ? 0 : (r ? 1 : 2);
                m_rem = (m_kind == 2) ? BR_LAT : CR_LAT;
            end
        end else begin
            if (!ch && !m_first) m_err = 1;
            m_first = 0;
            m_rem = m_rem - 1;
            if (m_rem == 0) m_wait = 0;
        end
    endtask

    task automatic check(input string name, input logic [9:0] e);
        logic [9:0] act;
        act = {pc_stall, ifid_stall, ifid_flush, idex_bubble, redirect,
               clr_call_haz, clr_ret_haz, clr_branch_haz, ctrl_err, busy};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, e);
        end else begin
            $display("check %s: outputs %b", name, act);
        end
    endtask

    task automatic drive(input logic [6:0] s);
        {data_hazard, id_valid, id_call, id_ret, id_branch, br_taken, control_hazard} = s;
    endtask

    task automatic apply_check(input logic [6:0] s, input logic [9:0] e, input string name);
        @(posedge clk); #1;
        drive(s);
        @(negedge clk);
        check(name, e);
        model_step(s);
    endtask

    task automatic apply_model(input logic [6:0] s, input string name);
        logic [9:0] e;
        @(posedge clk); #1;
        drive(s);
        e = model_expect(s);
        @(negedge clk);
        check(name, e);
        model_step(s);
    endtask

    initial begin
        tbl[0]  = '{7'b0000000, 10'b0000000000};  // idle
        tbl[1]  = '{7'b1000000, 10'b1101000000};  // data hazard stall
        tbl[2]  = '{7'b0100100, 10'b0000000000};  // branch issue
        tbl[3]  = '{7'b0000011, 10'b1010100101};  // branch resolve taken
        tbl[4]  = '{7'b0000000, 10'b0000000000};
        tbl[5]  = '{7'b0110100, 10'b0000000000};  // call+branch: call wins
        tbl[6]  = '{7'b1000001, 10'b1011000001};  // wait, dh forces bubble only
        tbl[7]  = '{7'b0000001, 10'b1010110001};  // call resolve
        tbl[8]  = '{7'b0001000, 10'b0000000000};  // ret without valid: no issue
        tbl[9]  = '{7'b0101100, 10'b0000000000};  // ret+branch: ret wins
        tbl[10] = '{7'b0110000, 10'b1010000001};  // first wait cycle, ch low ok, ID ignored
        tbl[11] = '{7'b0000001, 10'b1010101001};  // ret resolve
        tbl[12] = '{7'b0100100, 10'b0000000000};  // branch issue
        tbl[13] = '{7'b0000001, 10'b1010000101};  // not taken: clr, no redirect
        tbl[14] = '{7'b1100100, 10'b1101000000};  // dh blocks issue
        tbl[15] = '{7'b1100100, 10'b1101000000};
        tbl[16] = '{7'b0100100, 10'b0000000000};  // issue once dh drops

        model_reset();

        // Reset hold: outputs low while rst is high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), 10'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++)
            apply_check(7'b0, 10'b0, $sformatf("post_reset%0d", i));

        for (int i = 0; i < 17; i++)
            apply_check(tbl[i].stim, tbl[i].exp, $sformatf("vec%0d", i));
        apply_check(7'b0000011, 10'b1010100101, "dh_branch_resolve");
        apply_check(7'b0000000, 10'b0000000000, "dh_branch_run");

        // Reset arriving in the call's resolution cycle suppresses the clear pulse
        apply_check(7'b0110000, 10'b0000000000, "rst_call_issue");
        apply_check(7'b0000001, 10'b1010000001, "rst_call_wait");
        @(posedge clk); #1;
        drive(7'b0000001);
        rst = 1'b1;
        #1;
        check("rst_mid_wait", 10'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(7'b0);
        model_reset();
        for (int i = 0; i < 3; i++)
            apply_check(7'b0, 10'b0, $sformatf("rst_after%0d", i));

        // Randomized traffic with a well-behaved hazard detector
        for (int i = 0; i < 400; i++) begin
            logic [6:0] s;
            s[6] = ($urandom_range(3) == 0);
            s[5] = $urandom_range(1);
            s[4] = ($urandom_range(3) == 0);
            s[3] = ($urandom_range(3) == 0);
            s[2] = ($urandom_range(2) == 0);
            s[1] = $urandom_range(1);
            s[0] = m_wait ? (m_first ? 1'($urandom_range(1)) : 1'b1) : 1'b0;
            apply_model(s, $sformatf("rand%0d", i));
        end
        apply_model(7'b0, "rand_drain0");
        apply_model(7'b0, "rand_drain1");
        apply_model(7'b0, "rand_drain2");

        // Protocol errors: stray control_hazard in RUN, then a dropped flag mid-wait
        apply_check(7'b0000001, 10'b0000000000, "err_run_ch");
        apply_check(7'b0000000, 10'b0000000010, "err_sticky0");
        apply_check(7'b0000000, 10'b0000000010, "err_sticky1");
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("err_cleared_by_rst", 10'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        apply_check(7'b0110000, 10'b0000000000, "err_call_issue");
        apply_check(7'b0000001, 10'b1010000001, "err_call_first");
        apply_check(7'b0000000, 10'b1010110001, "err_call_drop");
        apply_check(7'b0000000, 10'b0000000010, "err_wait_flag");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
